// File: rtl/sd_digit_serializer.sv
// Radix-2 Booth recoder: serializes a two's-complement operand as signed digits, MSD first.
// Optional nonzero-digit counter output is enabled by defining SDS_NZ_COUNT_EN.
module sd_digit_serializer #(
  parameter int unsigned Num_bits = 4,
  parameter int unsigned Idx_bits = 2
) (
  input  logic                clk,
  input  logic                asyn_reset_n,
  input  logic                enable,
  input  logic                load,
  input  logic [Num_bits-1:0] operand,
  output logic                busy,
  output logic [1:0]          digit_select,
  output logic                digit_valid,
  output logic [Idx_bits-1:0] digit_index,
  output logic                last_digit,
`ifdef SDS_NZ_COUNT_EN
  output logic [Idx_bits:0]   nz_count,
`endif
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [Num_bits:0]   sr_q, sr_d;
  logic [Idx_bits-1:0] cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                valid_q, valid_d;
  logic [Idx_bits-1:0] idx_q, idx_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [1:0]          code;

  // Digit of weight i is x(i-1) - x(i), read from the top two bits of sr.
  always_comb begin
    unique case (sr_q[Num_bits -: 2])
      2'b01:   code = 2'b10;
      2'b10:   code = 2'b01;
      default: code = 2'b00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            sr_d    = {operand, 1'b0};
            cnt_d   = Idx_bits'(Num_bits - 1);
            state_d = StRun;
          end
        end
        StRun: begin
          sel_d   = code;
          idx_d   = cnt_q;
          valid_d = 1'b1;
          last_d  = (cnt_q == '0);
          sr_d    = {sr_q[Num_bits-1:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StDone;
        end
        StDone: begin
          done_d  = 1'b1;
          last_d  = 1'b0;
          sel_d   = 2'b00;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef SDS_NZ_COUNT_EN
  logic [Idx_bits:0] nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (enable) begin
      if (state_q == StIdle && load) nz_d = '0;
      else if (state_q == StRun && code != 2'b00) nz_d = nz_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) nz_q <= '0;
    else               nz_q <= nz_d;
  end

  assign nz_count = nz_q;
`endif

  assign busy         = (state_q != StIdle);
  assign digit_select = sel_q;
  assign digit_valid  = valid_q;
  assign digit_index  = idx_q;
  assign last_digit   = last_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sd_digit_serializer.sv
// Randomized self-checking bench for sd_digit_serializer against a Booth-recoding model.
// Define SDS_NZ_COUNT_EN to also check nz_count.
module tb_sd_digit_serializer;
  localparam int N  = 4;
  localparam int IB = 2;
  localparam int OW = 6 + IB;

  logic          clk = 1'b0;
  logic          asyn_reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  operand = '0;
  logic          busy;
  logic [1:0]    digit_select;
  logic          digit_valid;
  logic [IB-1:0] digit_index;
  logic          last_digit;
  logic          done;
`ifdef SDS_NZ_COUNT_EN
  logic [IB:0]   nz_count;
`endif

  int passed = 0;
  int total  = 0;

  sd_digit_serializer #(.Num_bits(N), .Idx_bits(IB)) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .enable       (enable),
    .load         (load),
    .operand      (operand),
    .busy         (busy),
    .digit_select (digit_select),
    .digit_valid  (digit_valid),
    .digit_index  (digit_index),
    .last_digit   (last_digit),
`ifdef SDS_NZ_COUNT_EN
    .nz_count     (nz_count),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] obs();
    return {busy, digit_valid, digit_select, digit_index, last_digit, done};
  endfunction

  // Digit list MSD first: d(i) = x(i-1) - x(i), encoded +1 -> 10, -1 -> 01, 0 -> 00.
  function automatic void model(input logic [N-1:0] op, output logic [1:0] codes [N],
                                output int nz);
    int d;
    nz = 0;
    for (int k = 0; k < N; k++) begin
      int pos = N - 1 - k;
      int xi  = int'(op[pos]);
      int xm  = (pos == 0) ? 0 : int'(op[pos-1]);
      d = xm - xi;
      codes[k] = (d == 1) ? 2'b10 : (d == -1) ? 2'b01 : 2'b00;
      if (d != 0) nz++;
    end
  endfunction

  task automatic test_reset();
    asyn_reset_n = 1'b0;
    load = 1'b0;
    enable = 1'b1;
    tick();
    total++;
    if (obs() !== '0) $display("FAIL reset_outputs: got %h want %h", obs(), {OW{1'b0}});
    else passed++;
    #2 asyn_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_gated();
    enable = 1'b0;
    load = 1'b1;
    operand = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (obs() !== '0) $display("FAIL load_gated: got %h want %h", obs(), {OW{1'b0}});
      else passed++;
    end
    load = 1'b0;
    enable = 1'b1;
  endtask

  // mode 0: no stall, 1: three-cycle stall after the 2nd digit, 2: random enable.
  task automatic test_stream(input logic [N-1:0] op, input int mode, input bit poke);
    logic [1:0]    codes [N];
    int            nz, k, stalls;
    bit            en, fin;
    logic [1:0]    held_sel;
    logic          held_last;
    logic [IB-1:0] held_idx;
    logic [OW-1:0] exp_v;
    model(op, codes, nz);
    enable = 1'b1;
    load = 1'b1;
    operand = op;
    tick();
    load = poke;
    operand = poke ? 4'b0101 : N'($urandom);
    held_sel = digit_select === 2'b00 ? 2'b00 : 2'b00;
    held_last = 1'b0;
    held_idx = digit_index;
    total++;
    if ({busy, digit_valid, done} !== 3'b100)
      $display("FAIL stream_accept op=%b: got %b want 100", op, {busy, digit_valid, done});
    else passed++;
    k = 0;
    stalls = 0;
    fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (mode == 1)      en = !(k == 2 && stalls < 3);
      else if (mode == 2) en = ($urandom_range(0, 3) != 0);
      else                en = 1'b1;
      if (!en) stalls++;
      enable = en;
      tick();
      if (!en) begin
        exp_v = {1'b1, 1'b0, held_sel, held_idx, held_last, 1'b0};
      end else if (k < N) begin
        held_sel = codes[k];
        held_idx = IB'(N - 1 - k);
        held_last = (k == N - 1);
        exp_v = {1'b1, 1'b1, held_sel, held_idx, held_last, 1'b0};
        k++;
      end else begin
        held_sel = 2'b00;
        held_last = 1'b0;
        exp_v = {1'b0, 1'b0, 2'b00, held_idx, 1'b0, 1'b1};
        fin = 1'b1;
      end
      total++;
      if (obs() !== exp_v)
        $display("FAIL stream op=%b k=%0d en=%b: got %h want %h", op, k, en, obs(), exp_v);
      else passed++;
    end
    load = 1'b0;
    enable = 1'b1;
    if (!fin) begin
      total++;
      $display("FAIL stream_timeout op=%b: got no done want done", op);
    end
    tick();
    total++;
    if ({busy, digit_valid, done} !== 3'b000)
      $display("FAIL stream_after op=%b: got %b want 000", op, {busy, digit_valid, done});
    else passed++;
`ifdef SDS_NZ_COUNT_EN
    total++;
    if (nz_count !== (IB + 1)'(nz))
      $display("FAIL nz_count op=%b: got %0d want %0d", op, nz_count, nz);
    else passed++;
`endif
  endtask

  task automatic test_directed();
    test_stream(4'b0110, 0, 1'b0);
    test_stream(4'b1000, 0, 1'b0);
    test_stream(4'b1111, 0, 1'b0);
    test_stream(4'b0000, 0, 1'b0);
    test_stream(4'b0110, 1, 1'b0);
    test_stream(4'b0110, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++)
      test_stream(N'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_abort();
    enable = 1'b1;
    load = 1'b1;
    operand = 4'b0110;
    tick();
    load = 1'b0;
    tick();
    tick();
    #2 asyn_reset_n = 1'b0;
    #1;
    total++;
    if (obs() !== '0) $display("FAIL abort_immediate: got %h want %h", obs(), {OW{1'b0}});
    else passed++;
    tick();
    #2 asyn_reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (obs() !== '0) $display("FAIL abort_quiet c=%0d: got %h want %h", c, obs(), {OW{1'b0}});
      else passed++;
    end
    test_stream(4'b1111, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]    codes [N];
    int            nz;
    logic [N-1:0]  op;
    logic [OW-1:0] exp_v;
    logic [IB-1:0] held_idx;
    enable = 1'b1;
    load = 1'b1;
    held_idx = digit_index;
    for (int g = 0; g < 4; g++) begin
      op = N'($urandom);
      operand = op;
      model(op, codes, nz);
      for (int p = 0; p < N + 2; p++) begin
        tick();
        if (p == 0) operand = ~op;
        if (p == 0) begin
          exp_v = {1'b1, 1'b0, 2'b00, held_idx, 1'b0, 1'b0};
        end else if (p <= N) begin
          held_idx = IB'(N - p);
          exp_v = {1'b1, 1'b1, codes[p-1], held_idx, p == N, 1'b0};
        end else begin
          exp_v = {1'b0, 1'b0, 2'b00, held_idx, 1'b0, 1'b1};
        end
        total++;
        if (obs() !== exp_v)
          $display("FAIL back_to_back g=%0d p=%0d: got %h want %h", g, p, obs(), exp_v);
        else passed++;
      end
    end
    load = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_gated();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/sd_digit_serializer.md
Name: sd_digit_serializer

Overview:
- Producer end of the signed-digit select interface consumed by the SDVM vector-select stage.
- Takes a two's-complement binary operand and recodes it with radix-2 Booth recoding into a stream of signed digits in {-1, 0, +1}.
- Emits one digit per enabled clock, MSD first, using the same 2-bit digit_select code: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0.
- Has a load/busy/done handshake toward the controller and honours the shared `enable` stall.

Parameters:
- Num_bits, 4: operand width and number of digits emitted per operand (must be >= 2).
- Idx_bits, 2: width of digit_index; must be >= ceil(log2(Num_bits)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- asyn_reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  global advance qualifier; when 0 all state freezes.
- load  input  1  request to start serializing `operand`; sampled only in IDLE.
- operand  input  Num_bits  two's-complement multiplier operand.
- busy  output  1  high whenever state != IDLE (combinational from state).
- digit_select  output  2  registered signed-digit code, same encoding as the SDVM digit_select input.
- digit_valid  output  1  registered; high for exactly the cycles carrying a new digit.
- digit_index  output  Idx_bits  registered weight of the current digit (Num_bits-1 down to 0).
- last_digit  output  1  registered; high with the digit of weight 0.
- done  output  1  registered one-cycle pulse after the last digit.

Behaviour:
- Reset (asyn_reset_n=0): takes effect immediately and asynchronously.
  - State = IDLE; shift register and counter cleared.
  - digit_select=2'b00, digit_valid=0, digit_index=0, last_digit=0, done=0.
  - Reset asserted mid-operand aborts the operand; no further digits or done are produced.
- Internal storage: shift register sr[Num_bits:0] loaded as {operand, 1'b0}, where the appended bit is x(-1)=0. Down-counter cnt holds the weight of the next digit.
- Digit rule: the digit of weight i is x(i-1) - x(i), taken from the top pair {sr[Num_bits], sr[Num_bits-1]}:
  - 00 -> 0 (2'b00)
  - 11 -> 0 (2'b00)
  - 01 -> +1 (2'b10)
  - 10 -> -1 (2'b01)
  - Sum over i of d(i)*2^i equals the signed operand exactly, including the most negative value.
- Any edge with enable=0: no state change; digit_valid<=0, done<=0; digit_select, digit_index and last_digit hold their values.
- States; all transitions below require enable=1:
  - IDLE: load=1 -> sr<={operand,0}, cnt<=Num_bits-1, go to RUN. Outputs keep their reset/idle values; digit_valid=0.
  - RUN: each edge drives digit_select<=code(top pair), digit_index<=cnt, digit_valid<=1, last_digit<=(cnt==0). Then sr shifts left by 1 and cnt decrements. When cnt==0 on this edge, go to DONE.
  - DONE: one edge drives done<=1, digit_valid<=0, last_digit<=0, digit_select<=2'b00, then go to IDLE.
- load in RUN or DONE is ignored; the operand is not captured. load in IDLE with enable=0 is not accepted.
- Latency with enable held high:
  - load accepted at edge k.
  - Digits visible after edges k+1 .. k+Num_bits.
  - done visible after edge k+Num_bits+1.
  - Next load can be accepted at edge k+Num_bits+2.
- Throughput: one operand per Num_bits+2 enabled cycles.
- Downstream: the SDVM stage registers digit_select internally (one-cycle delay), so the consumer aligns vec_in to digit_valid plus one cycle. This block adds no extra compensation.

Optional Feature:
- Macro SDS_NZ_COUNT_EN.
- When defined: adds output nz_count (width Idx_bits+1), the number of nonzero digits emitted for the current operand.
  - Cleared to 0 when load is accepted.
  - Incremented on each RUN edge that emits 2'b10 or 2'b01.
  - Held through DONE and IDLE until the next accepted load.
  - Reset value 0.
- When undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Num_bits=4, operand=4'b0110 (+6), load pulse, enable=1 -> digit_select sequence 10,00,01,00; digit_index 3,2,1,0; last_digit on index 0; done one cycle later; nz_count=2 with macro.
- operand=4'b1000 (-8) -> 01,00,00,00. operand=4'b1111 (-1) -> 00,00,00,01. operand=0 -> four 00 digits with digit_valid=1.
- operand=4'b0110, enable low for 3 cycles after the 2nd digit -> digit_valid=0 during the stall; digit_select holds 00; resumes with 01,00; total digit_valid count = 4.
- load=1 with operand=4'b0101 asserted during RUN of 4'b0110 -> ignored; stream stays 10,00,01,00; done pulse once.
- asyn_reset_n driven low asynchronously after the 2nd digit of 4'b0110 -> outputs 0 and busy=0 immediately; no done; after release a new load of 4'b1111 gives 00,00,00,01.
- Back-to-back: load held high continuously -> operands accepted every Num_bits+2 cycles; busy low exactly one cycle between operands.
